lsu_mem_ctrl: RTL and testbench

Load/store memory sequencer between the load-store station's issue port and the data memory. Accepts one issued load or store per transaction and computes the effective address. It runs the request/acknowledge handshake with data memory, then arbitrates for the CDB to report completion (load result or store done). While a transaction is in flight it asserts `lsu_busy`, which feeds the station's `stall_hazard`.

---
 rtl/lsu_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory sequencer: accepts one issued load/store, runs the data
// memory req/ack handshake, then reports completion on the CDB. A recovery
// matching the in-flight ROB tag kills the transaction; the memory handshake
// still finishes, but nothing is broadcast.
module lsu_mem_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic              mem_ren_in,
   input  logic              mem_wen_in,
   input  logic [5:0]        p_rd_in,
   input  logic [3:0]        rob_num_in,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [15:0]       immed,
   input  logic              recover,
   input  logic [3:0]        rob_num_rec,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              cdb_req,
   input  logic              cdb_grant,
   output logic [5:0]        cdb_p_rd,
   output logic [DATA_W-1:0] cdb_data,
   output logic [3:0]        cdb_rob_num,
   output logic              cdb_RegDest,
   output logic              lsu_busy,
   output logic              mem_timeout
);

   typedef enum logic [1:0] {IDLE, MEM, CDB} state_t;

   localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

   state_t            state, state_nxt;
   logic              is_load;
   logic [5:0]        p_rd;
   logic [3:0]        rob_num;
   logic [DATA_W-1:0] addr, wdata, rdata;
   logic              killed;
   logic [7:0]        wait_cnt;

   logic              accept, kill_hit;
   logic [DATA_W-1:0] immed_sext;

   assign immed_sext = {{(DATA_W-16){immed[15]}}, immed};
   // Only an IDLE sequencer takes new work; recovery that cycle blocks it.
   assign accept     = (state == IDLE) && issue && !recover && (mem_ren_in || mem_wen_in);
   assign kill_hit   = (state != IDLE) && recover && (rob_num_rec == rob_num);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and output decode; outputs depend on registered state only
   always_comb begin
      state_nxt   = state;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = '0;
      dmem_wdata  = '0;
      cdb_req     = 1'b0;
      cdb_p_rd    = '0;
      cdb_data    = '0;
      cdb_rob_num = '0;
      cdb_RegDest = 1'b0;
      lsu_busy    = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept) state_nxt = MEM;
         end
         MEM: begin
            dmem_req   = 1'b1;
            dmem_we    = !is_load;
            dmem_addr  = addr;
            dmem_wdata = is_load ? '0 : wdata;
            // A kill landing with the ack still suppresses the broadcast.
            if (dmem_ack) state_nxt = (killed || kill_hit) ? IDLE : CDB;
         end
         CDB: begin
            if (!killed) begin
               cdb_req     = 1'b1;
               cdb_p_rd    = p_rd;
               cdb_rob_num = rob_num;
               cdb_data    = is_load ? rdata : '0;
               cdb_RegDest = is_load;
               if (cdb_grant) state_nxt = IDLE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction registers: latched on accept, load data captured on ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_load <= 1'b0;
         p_rd    <= '0;
         rob_num <= '0;
         addr    <= '0;
         wdata   <= '0;
         rdata   <= '0;
         killed  <= 1'b0;
      end else begin
         if (accept) begin
            is_load <= mem_ren_in;
            p_rd    <= p_rd_in;
            rob_num <= rob_num_in;
            addr    <= rs_data + immed_sext;
            wdata   <= rt_data;
            rdata   <= '0;
            killed  <= 1'b0;
         end else begin
            if (state == MEM && dmem_ack && is_load) rdata <= dmem_rdata;
            if (kill_hit) killed <= 1'b1;
         end
      end
   end

   // Saturating wait counter for unacknowledged MEM cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                               wait_cnt <= '0;
      else if (accept)                                       wait_cnt <= '0;
      else if (state == MEM && !dmem_ack && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
   end

   // Sticky timeout: set when the count reaches the limit, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_timeout <= 1'b0;
      else if (state == MEM && !dmem_ack && ({1'b0, wait_cnt} + 9'd1 >= TMO_LIM))
         mem_timeout <= 1'b1;
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed + randomized bench for lsu_mem_ctrl. Expected values come from a
// transaction-level model: effective address arithmetic, per-phase cycle
// timing, kill rules, and counts of memory handshakes and CDB broadcasts.
module tb_lsu_mem_ctrl;
   localparam int DW  = 32;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue, mem_ren_in, mem_wen_in;
   logic [5:0]    p_rd_in;
   logic [3:0]    rob_num_in;
   logic [DW-1:0] rs_data, rt_data;
   logic [15:0]   immed;
   logic          recover;
   logic [3:0]    rob_num_rec;
   logic          dmem_req, dmem_we;
   logic [DW-1:0] dmem_addr, dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          cdb_req, cdb_grant;
   logic [5:0]    cdb_p_rd;
   logic [DW-1:0] cdb_data;
   logic [3:0]    cdb_rob_num;
   logic          cdb_RegDest, lsu_busy, mem_timeout;

   lsu_mem_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .issue(issue), .mem_ren_in(mem_ren_in), .mem_wen_in(mem_wen_in),
      .p_rd_in(p_rd_in), .rob_num_in(rob_num_in), .rs_data(rs_data), .rt_data(rt_data),
      .immed(immed), .recover(recover), .rob_num_rec(rob_num_rec),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
      .cdb_p_rd(cdb_p_rd), .cdb_data(cdb_data), .cdb_rob_num(cdb_rob_num),
      .cdb_RegDest(cdb_RegDest), .lsu_busy(lsu_busy), .mem_timeout(mem_timeout));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int bcast = 0, hs = 0, exp_bcast = 0, exp_hs = 0;
   bit tmo_m = 1'b0;

   // Observed handshakes and broadcasts, counted at the active edge
   always @(posedge clk) begin
      if (cdb_req && cdb_grant) bcast++;
      if (dmem_req && dmem_ack) hs++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".dmem_req"}, 32'(dmem_req), 0);
      chk({tag, ".dmem_we"},  32'(dmem_we), 0);
      chk({tag, ".dmem_addr"}, dmem_addr, 0);
      chk({tag, ".dmem_wdata"}, dmem_wdata, 0);
      chk({tag, ".cdb_req"},  32'(cdb_req), 0);
      chk({tag, ".cdb_p_rd"}, 32'(cdb_p_rd), 0);
      chk({tag, ".cdb_data"}, cdb_data, 0);
      chk({tag, ".cdb_rob"},  32'(cdb_rob_num), 0);
      chk({tag, ".cdb_rd"},   32'(cdb_RegDest), 0);
      chk({tag, ".busy"},     32'(lsu_busy), 0);
   endtask

   task automatic clr_inputs();
      issue = 0; mem_ren_in = 0; mem_wen_in = 0; p_rd_in = 0; rob_num_in = 0;
      rs_data = 0; rt_data = 0; immed = 0; recover = 0; rob_num_rec = 0;
      dmem_ack = 0; dmem_rdata = 0; cdb_grant = 0;
   endtask

   // One transaction. kill_ph: 0 none, 1 recover during MEM cycle kill_at,
   // 2 recover during CDB cycle kill_at. Entered and left at a negedge.
   task automatic do_txn(input bit ld, input bit both, input logic [5:0] prd, input logic [3:0] rob,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                         input logic [31:0] rd, input int ack_dly, input int gnt_dly,
                         input int kill_ph, input int kill_at, input logic [3:0] ktag, input bit stray);
      logic [31:0] ea;
      bit killed, done;
      int j;
      ea = rs + {{16{imm[15]}}, imm};
      killed = 0;
      chk("pre.busy", 32'(lsu_busy), 0);
      issue = 1; mem_ren_in = ld; mem_wen_in = !ld || both;
      p_rd_in = prd; rob_num_in = rob; rs_data = rs; rt_data = rt; immed = imm;
      @(negedge clk);
      clr_inputs();
      for (int i = 0; i <= ack_dly; i++) begin
         chk("mem.req",   32'(dmem_req), 1);
         chk("mem.we",    32'(dmem_we), 32'(!ld));
         chk("mem.addr",  dmem_addr, ea);
         chk("mem.wdata", dmem_wdata, ld ? 32'd0 : rt);
         chk("mem.busy",  32'(lsu_busy), 1);
         chk("mem.cdb",   32'(cdb_req), 0);
         chk("mem.tmo",   32'(mem_timeout), 32'(tmo_m || i >= TMO));
         if (stray && i == 0) begin
            issue = 1; mem_ren_in = 1; rs_data = ~rs; immed = ~imm; rob_num_in = ~rob;
         end
         if (kill_ph == 1 && i == kill_at) begin
            recover = 1; rob_num_rec = ktag;
            if (ktag == rob) killed = 1;
         end
         if (i == ack_dly) begin dmem_ack = 1; dmem_rdata = rd; end
         @(negedge clk);
         clr_inputs();
      end
      exp_hs++;
      if (ack_dly >= TMO) tmo_m = 1;
      chk("post.tmo", 32'(mem_timeout), 32'(tmo_m));
      if (killed) begin
         chk("kmem.busy", 32'(lsu_busy), 0);
         chk("kmem.cdb",  32'(cdb_req), 0);
         chk("kmem.req",  32'(dmem_req), 0);
      end else begin
         done = 0;
         j = 0;
         while (!done) begin
            chk("cdb.req",  32'(cdb_req), 1);
            chk("cdb.prd",  32'(cdb_p_rd), 32'(prd));
            chk("cdb.rob",  32'(cdb_rob_num), 32'(rob));
            chk("cdb.data", cdb_data, ld ? rd : 32'd0);
            chk("cdb.rd",   32'(cdb_RegDest), 32'(ld));
            chk("cdb.busy", 32'(lsu_busy), 1);
            chk("cdb.dreq", 32'(dmem_req), 0);
            if (kill_ph == 2 && j == kill_at) begin
               recover = 1; rob_num_rec = ktag;
               if (ktag == rob && j < gnt_dly) killed = 1;
            end
            if (j == gnt_dly) cdb_grant = 1;
            @(negedge clk);
            clr_inputs();
            if (killed) begin
               chk("kcdb.req",  32'(cdb_req), 0);
               chk("kcdb.rob",  32'(cdb_rob_num), 0);
               chk("kcdb.busy", 32'(lsu_busy), 1);
               @(negedge clk);
               chk("kcdb.idle", 32'(lsu_busy), 0);
               done = 1;
            end else if (j == gnt_dly) begin
               exp_bcast++;
               chk("gnt.busy", 32'(lsu_busy), 0);
               chk("gnt.cdb",  32'(cdb_req), 0);
               done = 1;
            end
            j++;
         end
      end
      chk("bcast_cnt", 32'(bcast), 32'(exp_bcast));
      chk("hs_cnt",    32'(hs), 32'(exp_hs));
   endtask

   initial begin
      bit ld, both;
      int ad, gd, kp, ka;
      logic [3:0] rob, kt;
      clr_inputs();
      rst = 1;
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      chk("reset.tmo", 32'(mem_timeout), 0);
      rst = 0;
      @(negedge clk);

      // Load with negative offset, ack after 2 cycles, immediate grant
      do_txn(1, 0, 6'd5, 4'd3, 32'h100, 32'h0, 16'hFFFC, 32'hDEADBEEF, 2, 0, 0, 0, 4'd0, 0);
      // Store with address wrap, same-cycle ack and grant
      do_txn(0, 0, 6'd9, 4'd1, 32'hFFFFFFFF, 32'h55, 16'h0001, 32'h0, 0, 0, 0, 0, 4'd0, 0);
      // Both enables set -> load
      do_txn(1, 1, 6'd2, 4'd4, 32'h2000, 32'h77, 16'h0010, 32'h1234, 1, 1, 0, 0, 4'd0, 0);
      // Kill in MEM (tag 7), then a non-matching tag (6)
      do_txn(1, 0, 6'd11, 4'd7, 32'h40, 32'h0, 16'h4, 32'hCAFE, 3, 0, 1, 1, 4'd7, 0);
      do_txn(1, 0, 6'd11, 4'd7, 32'h40, 32'h0, 16'h4, 32'hCAFE, 3, 0, 1, 1, 4'd6, 0);
      // Kill on the ack cycle
      do_txn(0, 0, 6'd1, 4'd2, 32'h80, 32'h9, 16'h0, 32'h0, 2, 0, 1, 2, 4'd2, 0);
      // Backpressure 4 cycles then kill; kill on the grant cycle
      do_txn(1, 0, 6'd33, 4'd9, 32'h500, 32'h0, 16'h8, 32'hA5A5, 0, 6, 2, 4, 4'd9, 0);
      do_txn(1, 0, 6'd34, 4'd10, 32'h500, 32'h0, 16'h8, 32'h5A5A, 0, 2, 2, 2, 4'd10, 0);
      // Stray issue while busy is ignored
      do_txn(0, 0, 6'd3, 4'd5, 32'h1000, 32'hBEEF, 16'h20, 32'h0, 1, 1, 0, 0, 4'd0, 1);

      // Recover blocks accept; grant/ack while idle and issue without op are ignored
      issue = 1; mem_ren_in = 1; recover = 1; rob_num_rec = 4'd3;
      @(negedge clk);
      clr_inputs();
      chk_quiet("blk");
      issue = 1; cdb_grant = 1; dmem_ack = 1;
      @(negedge clk);
      clr_inputs();
      chk_quiet("idle_noise");
      chk("idle.bcast", 32'(bcast), 32'(exp_bcast));

      // Timeout: 20 unacked cycles, then sticky across a clean transaction
      do_txn(1, 0, 6'd7, 4'd8, 32'h300, 32'h0, 16'h0, 32'h11, 20, 1, 0, 0, 4'd0, 0);
      chk("tmo.set", 32'(mem_timeout), 1);
      do_txn(0, 0, 6'd7, 4'd8, 32'h300, 32'h66, 16'h0, 32'h0, 0, 0, 0, 0, 4'd0, 0);
      chk("tmo.sticky", 32'(mem_timeout), 1);

      // Async reset mid-MEM, between edges
      issue = 1; mem_ren_in = 1; rs_data = 32'h44; rob_num_in = 4'd1;
      @(negedge clk);
      clr_inputs();
      chk("rst.pre_req", 32'(dmem_req), 1);
      #2 rst = 1;
      #1;
      chk_quiet("rst_mid");
      chk("rst.tmo", 32'(mem_timeout), 0);
      tmo_m = 0;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk_quiet("after_rst");
      chk("rst.hs", 32'(hs), 32'(exp_hs));

      // Randomized transactions
      for (int t = 0; t < 60; t++) begin
         ld   = 1'($urandom_range(0, 1));
         both = ld && ($urandom_range(0, 3) == 0);
         rob  = 4'($urandom);
         ad   = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 4));
         gd   = int'($urandom_range(0, 4));
         kp   = int'($urandom_range(0, 2));
         ka   = (kp == 1) ? int'($urandom_range(0, ad)) : int'($urandom_range(0, gd));
         kt   = $urandom_range(0, 1) ? rob : 4'($urandom);
         do_txn(ld, both, 6'($urandom), rob, $urandom, $urandom, 16'($urandom), $urandom,
                ad, gd, kp, ka, kt, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("gap.busy", 32'(lsu_busy), 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
